wb_reg_file: RTL and testbench
==============================

Name: wb_reg_file

Overview:
Writeback-side consumer of the MEM/WB pipeline buffer outputs (write enable, destination index, end result) for the pipelined CPU. It holds the architectural register file and commits writebacks. It serves two combinational read ports to decode. A per-register pending-write scoreboard raises a decode stall on RAW hazards.

Parameters:
BIT_WIDTH, 32, data width of each register and of writeback/read data
REG_INDEX_BIT_WIDTH, 4, register index width; NUM_REGS = 2**REG_INDEX_BIT_WIDTH (16), derived, not overridable
SB_CNT_WIDTH, 2, width of per-register in-flight write counter (max 3 outstanding writes per register)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wb_wrt_en  input  1  writeback commit, from MEM/WB buffer reg_file_wrt_en_out
wb_dst_ind  input  REG_INDEX_BIT_WIDTH  writeback destination, from MEM/WB dst_ind_out
wb_res  input  BIT_WIDTH  writeback data, from MEM/WB end_res_out
issue_en  input  1  decode issues an instruction that will write issue_dst_ind
issue_dst_ind  input  REG_INDEX_BIT_WIDTH  destination of issuing instruction
src1_used, src2_used  input  1 each  decode actually reads that source
src1_ind, src2_ind  input  REG_INDEX_BIT_WIDTH each  read indices
src1_data, src2_data  output  BIT_WIDTH each  combinational read data
hazard_stall  output  1  combinational; decode must hold
sb_err  output  1  sticky scoreboard protocol-error flag

Behaviour:
- Reset, sync active-high: all NUM_REGS registers <= 0; all counters <= 0; sb_err <= 0. Any wb/issue in a reset cycle is ignored. Reset mid-operation discards all pending state, with no partial commit.
- Outputs after reset: src*_data = 0, hazard_stall = 0, sb_err = 0.
- No hardwired-zero register; all 16 are writable.
- Write: on posedge with wb_wrt_en=1, regs[wb_dst_ind] <= wb_res. Read ports are asynchronous: src*_data = regs[src*_ind] (bypass is governed by the optional feature).
- Scoreboard, per register r, counter cnt[r]:
  - inc = issue_en & !hazard_stall & (issue_dst_ind==r)
  - dec = wb_wrt_en & (wb_dst_ind==r)
  - inc & dec: cnt unchanged.
  - inc only: cnt+1. If already 2**SB_CNT_WIDTH-1, it saturates and sb_err <= 1.
  - dec only: cnt-1. If already 0, it stays 0 and sb_err <= 1 (a write is still committed to the array).
  - issue_en while hazard_stall=1 is not accepted: no counter change and no error.
- busy(r) = cnt[r] != 0.
- hazard_stall = (src1_used & busy(src1_ind) & !release(src1_ind)) | (same for src2). Without the optional feature, release() = 0.
- Same index on both sources, or issue_dst_ind equal to a source, needs no special case; the rules above apply.
- sb_err clears only on reset.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - src*_data = wb_res when wb_wrt_en & wb_dst_ind==src*_ind, else regs[].
  - release(r) = wb_wrt_en & wb_dst_ind==r & cnt[r]==1. The last outstanding write retiring this cycle clears the stall the same cycle.
  - Zero-cycle write-to-read latency.
- Undefined:
  - Reads return only the array, so a new value is visible the cycle after the write.
  - release()=0, so a stall on r lasts until the cycle after cnt[r] reaches 0.

Test Plan:
- Reset then read: hold reset 1 cycle, src1_ind=5, src2_ind=15 -> src1_data=src2_data=0x0, hazard_stall=0, sb_err=0.
- Plain write/read: wb_wrt_en=1, wb_dst_ind=3, wb_res=0xDEADBEEF for 1 cycle, src1_ind=3 -> src1_data=0xDEADBEEF next cycle (same cycle if WB_BYPASS_EN).
- RAW stall:
  - Stimulus: issue_en=1, issue_dst_ind=7; next cycle src2_used=1, src2_ind=7; wb of r7=0x1234 three cycles later.
  - Response: hazard_stall=1 until wb cycle (WB_BYPASS_EN: drops in wb cycle with src2_data=0x1234; otherwise drops cycle after).
- Double in-flight:
  - Stimulus: two accepted issues to r2 (cnt=2), then one wb to r2 with src1_used=1, src1_ind=2.
  - Response: still stalled (cnt=1) even with WB_BYPASS_EN; second wb clears it.
- Simultaneous inc/dec: cnt[4]=1, same cycle issue_en to r4 and wb to r4=0xA5 -> cnt[4] stays 1, regs[4]=0xA5, sb_err=0.
- Errors: wb to r9 with cnt[9]=0 -> regs[9] written, sb_err=1 sticky. Four accepted issues to r1 -> cnt saturates at 3, sb_err=1. Reset -> sb_err=0.

Source files
------------

// File: rtl/wb_reg_file.sv
// Architectural register file with a RAW-hazard scoreboard on the writeback side of the pipeline.
// Latency: reads are combinational; a writeback is visible the cycle after commit (same cycle with WB_BYPASS_EN).
// Backpressure: hazard_stall holds decode while a source register has an outstanding write; a stalled issue is dropped.
//
// Ports: clk/reset (sync, active-high); wb_wrt_en/wb_dst_ind/wb_res commit from MEM/WB;
//        issue_en/issue_dst_ind mark a new in-flight write; src{1,2}_used/_ind select reads,
//        src{1,2}_data return them; hazard_stall requests decode hold; sb_err is a sticky protocol error.
// Optional feature macro: WB_BYPASS_EN (writeback-to-read bypass and same-cycle stall release).
module wb_reg_file #(
    parameter int BIT_WIDTH           = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int SB_CNT_WIDTH        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wb_wrt_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_dst_ind,
    input  logic [BIT_WIDTH-1:0]           wb_res,
    input  logic                           issue_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] issue_dst_ind,
    input  logic                           src1_used,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_ind,
    input  logic                           src2_used,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src2_ind,
    output logic [BIT_WIDTH-1:0]           src1_data,
    output logic [BIT_WIDTH-1:0]           src2_data,
    output logic                           hazard_stall,
    output logic                           sb_err
);

    localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;
    localparam logic [SB_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_WIDTH-1:0] CNT_ONE = SB_CNT_WIDTH'(1);

    logic [BIT_WIDTH-1:0]    regs    [NUM_REGS];
    logic [SB_CNT_WIDTH-1:0] cnt     [NUM_REGS];
    logic [SB_CNT_WIDTH-1:0] cnt_nxt [NUM_REGS];
    logic                    err_set;
    logic                    rel1;
    logic                    rel2;
    logic                    issue_acc;

    // Read ports
    always_comb begin
        src1_data = regs[src1_ind];
        src2_data = regs[src2_ind];
`ifdef WB_BYPASS_EN
        if (wb_wrt_en && (wb_dst_ind == src1_ind)) src1_data = wb_res;
        if (wb_wrt_en && (wb_dst_ind == src2_ind)) src2_data = wb_res;
`endif
    end

    // A source is released early only when the last outstanding write to it retires this cycle.
`ifdef WB_BYPASS_EN
    assign rel1 = wb_wrt_en && (wb_dst_ind == src1_ind) && (cnt[src1_ind] == CNT_ONE);
    assign rel2 = wb_wrt_en && (wb_dst_ind == src2_ind) && (cnt[src2_ind] == CNT_ONE);
`else
    assign rel1 = 1'b0;
    assign rel2 = 1'b0;
`endif

    assign hazard_stall = (src1_used && (cnt[src1_ind] != '0) && !rel1)
                        | (src2_used && (cnt[src2_ind] != '0) && !rel2);

    // An issue during a stall is not accepted, so it never touches the scoreboard.
    assign issue_acc = issue_en && !hazard_stall;

    // Scoreboard next state: matching inc/dec cancel; over/underflow hold the count and flag an error.
    always_comb begin
        logic inc_r;
        logic dec_r;
        inc_r   = 1'b0;
        dec_r   = 1'b0;
        err_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_r      = issue_acc && (issue_dst_ind == REG_INDEX_BIT_WIDTH'(r));
            dec_r      = wb_wrt_en && (wb_dst_ind == REG_INDEX_BIT_WIDTH'(r));
            cnt_nxt[r] = cnt[r];
            if (inc_r && !dec_r) begin
                if (cnt[r] == CNT_MAX) err_set = 1'b1;
                else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
            end else if (dec_r && !inc_r) begin
                if (cnt[r] == '0) err_set = 1'b1;
                else              cnt_nxt[r] = cnt[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs   <= '{default: '0};
            cnt    <= '{default: '0};
            sb_err <= 1'b0;
        end else begin
            // An unexpected writeback is still committed; only the error flag records it.
            if (wb_wrt_en) regs[wb_dst_ind] <= wb_res;
            cnt <= cnt_nxt;
            if (err_set) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// Bench for wb_reg_file: directed steps from the test plan followed by random traffic,
// all compared against a reference model built from integer counters and a plain array.
module tb_wb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wrt_en;
    logic [3:0]  wb_dst_ind;
    logic [31:0] wb_res;
    logic        issue_en;
    logic [3:0]  issue_dst_ind;
    logic        src1_used;
    logic [3:0]  src1_ind;
    logic        src2_used;
    logic [3:0]  src2_ind;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    logic        hazard_stall;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err;

    always #5 clk = ~clk;

    wb_reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .wb_wrt_en    (wb_wrt_en),
        .wb_dst_ind   (wb_dst_ind),
        .wb_res       (wb_res),
        .issue_en     (issue_en),
        .issue_dst_ind(issue_dst_ind),
        .src1_used    (src1_used),
        .src1_ind     (src1_ind),
        .src2_used    (src2_used),
        .src2_ind     (src2_ind),
        .src1_data    (src1_data),
        .src2_data    (src2_data),
        .hazard_stall (hazard_stall),
        .sb_err       (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [3:0] ind);
`ifdef WB_BYPASS_EN
        if (wb_wrt_en && wb_dst_ind == ind) return wb_res;
`endif
        return m_regs[ind];
    endfunction

    // Source is blocked if it has pending writes, unless (bypass build) the final one lands now.
    function automatic bit src_blocked(input bit used, input logic [3:0] ind);
        bit released;
        released = 1'b0;
`ifdef WB_BYPASS_EN
        released = wb_wrt_en && (wb_dst_ind == ind) && (m_cnt[ind] == 1);
`endif
        return used && (m_cnt[ind] > 0) && !released;
    endfunction

    function automatic bit exp_stall();
        return src_blocked(src1_used, src1_ind) || src_blocked(src2_used, src2_ind);
    endfunction

    // One clock: compare all outputs mid-cycle, then advance the model with the DUT edge.
    task automatic step();
        bit st;
        @(negedge clk);
        if (!reset) begin
            chk("src1_data", src1_data, exp_data(src1_ind));
            chk("src2_data", src2_data, exp_data(src2_ind));
            chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, exp_stall()});
            chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
        end
        st = exp_stall();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = '0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                bit inc, dec;
                inc = issue_en && !st && (issue_dst_ind == 4'(r));
                dec = wb_wrt_en && (wb_dst_ind == 4'(r));
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] + 1;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
            if (wb_wrt_en) m_regs[wb_dst_ind] = wb_res;
        end
        #1;
    endtask

    task automatic idle();
        wb_wrt_en = 0; issue_en = 0; src1_used = 0; src2_used = 0;
    endtask

    task automatic issue(input logic [3:0] d);
        issue_en = 1; issue_dst_ind = d; step(); issue_en = 0;
    endtask

    initial begin
        bit byp;
`ifdef WB_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        for (int r = 0; r < 16; r++) begin m_regs[r] = 'x; m_cnt[r] = 0; end
        m_err = 1'b0;
        reset = 1; idle(); wb_dst_ind = 0; wb_res = 0; issue_dst_ind = 0;
        src1_ind = 5; src2_ind = 15;
        step();
        reset = 0;

        // Reset then read
        #2;
        chk("rst_src1", src1_data, 32'h0);
        chk("rst_src2", src2_data, 32'h0);
        chk("rst_stall", {31'b0, hazard_stall}, 32'h0);
        chk("rst_err", {31'b0, sb_err}, 32'h0);
        step();

        // Plain write/read (issued first so the writeback is expected)
        issue(4'd3);
        wb_wrt_en = 1; wb_dst_ind = 3; wb_res = 32'hDEADBEEF; src1_ind = 3;
        #2;
        if (byp) chk("wr_byp_same", src1_data, 32'hDEADBEEF);
        step();
        wb_wrt_en = 0;
        #2 chk("wr_next", src1_data, 32'hDEADBEEF);
        step();

        // RAW stall on r7
        issue(4'd7);
        src2_used = 1; src2_ind = 7;
        #2 chk("raw_c1", {31'b0, hazard_stall}, 32'h1);
        step(); step();
        wb_wrt_en = 1; wb_dst_ind = 7; wb_res = 32'h1234;
        #2 chk("raw_wb_stall", {31'b0, hazard_stall}, byp ? 32'h0 : 32'h1);
        if (byp) chk("raw_wb_data", src2_data, 32'h1234);
        step();
        wb_wrt_en = 0;
        #2 chk("raw_after", {31'b0, hazard_stall}, 32'h0);
        chk("raw_after_data", src2_data, 32'h1234);
        step();
        idle();

        // Two writes in flight to r2
        issue(4'd2); issue(4'd2);
        src1_used = 1; src1_ind = 2; wb_wrt_en = 1; wb_dst_ind = 2; wb_res = 32'h22;
        #2 chk("dbl_first", {31'b0, hazard_stall}, 32'h1);
        step();
        wb_res = 32'h23;
        #2 chk("dbl_second", {31'b0, hazard_stall}, byp ? 32'h0 : 32'h1);
        step();
        wb_wrt_en = 0;
        #2 chk("dbl_clear", {31'b0, hazard_stall}, 32'h0);
        step();
        idle();

        // Simultaneous inc/dec on r4
        issue(4'd4);
        issue_en = 1; issue_dst_ind = 4; wb_wrt_en = 1; wb_dst_ind = 4; wb_res = 32'hA5;
        step();
        idle(); src1_used = 1; src1_ind = 4;
        #2 chk("incdec_data", src1_data, 32'hA5);
        chk("incdec_busy", {31'b0, hazard_stall}, 32'h1);
        chk("incdec_err", {31'b0, sb_err}, 32'h0);
        step();
        src1_used = 0; wb_wrt_en = 1; wb_dst_ind = 4; wb_res = 32'hA6;
        step();
        idle();

        // Underflow: unexpected wb to r9 still commits
        wb_wrt_en = 1; wb_dst_ind = 9; wb_res = 32'h99; step(); idle();
        src1_ind = 9;
        #2 chk("uf_data", src1_data, 32'h99);
        chk("uf_err", {31'b0, sb_err}, 32'h1);
        step();
        #2 chk("uf_sticky", {31'b0, sb_err}, 32'h1);
        reset = 1; step(); reset = 0;

        // Overflow: fourth issue to r1 saturates
        issue(4'd1); issue(4'd1); issue(4'd1);
        #2 chk("of_three", {31'b0, sb_err}, 32'h0);
        issue(4'd1);
        #2 chk("of_four", {31'b0, sb_err}, 32'h1);
        src1_used = 1; src1_ind = 1; wb_wrt_en = 1; wb_dst_ind = 1; wb_res = 32'h11;
        step(); step();
        #2 chk("of_sat_stall", {31'b0, hazard_stall}, byp ? 32'h0 : 32'h1);
        step();
        idle();
        reset = 1; step(); reset = 0;
        #2 chk("rst_clears_err", {31'b0, sb_err}, 32'h0);

        // Random traffic on a few registers to force interaction
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 79) == 0);
            issue_en      = $urandom_range(0, 1);
            issue_dst_ind = 4'($urandom_range(0, 3));
            wb_wrt_en     = ($urandom_range(0, 2) == 0);
            wb_dst_ind    = 4'($urandom_range(0, 3));
            wb_res        = $urandom;
            src1_used     = $urandom_range(0, 1);
            src1_ind      = 4'($urandom_range(0, 4));
            src2_used     = $urandom_range(0, 1);
            src2_ind      = 4'($urandom_range(0, 4));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
